// File: rtl/nco_ctrl_pkg.sv
// Shared definitions for the NCO sweep controller.
//   state_e   : sequencer state encoding
//   DEF_*     : default widths (phase increment, tone count, dwell, divider)
//   nz_to_one : maps a zero count to 1 so programmed counts are never empty
package nco_ctrl_pkg;

  localparam int DEF_APR = 16;
  localparam int DEF_NW  = 12;
  localparam int DEF_DW  = 16;
  localparam int DEF_VW  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int unsigned nz_to_one(input int unsigned v);
    return (v == 0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/nco_clken_div.sv
// Sample-rate divider producing the NCO clock-enable.
//   clk, reset_n : system clock, async active-low reset
//   i_clr        : restart the period with an enable pulse on the next cycle
//   i_en         : keep counting on the next cycle; low parks the divider at 0
//   i_div        : period minus 1
//   o_clken      : registered pulse, high in cycles where the count is 0
module nco_clken_div
  import nco_ctrl_pkg::*;
#(
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [VW-1:0] i_div,
  output logic          o_clken
);

  logic [VW-1:0] r_cnt;
  logic          r_clken;

  // r_cnt is the count of the current cycle; r_clken mirrors (r_cnt == 0)
  // while enabled so the pulse comes straight from a flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_clken <= 1'b0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_clken <= 1'b1;
    end else if (i_en) begin
      if (r_cnt == i_div) begin
        r_cnt   <= '0;
        r_clken <= 1'b1;
      end else begin
        r_cnt   <= r_cnt + 1'b1;
        r_clken <= 1'b0;
      end
    end else begin
      r_cnt   <= '0;
      r_clken <= 1'b0;
    end
  end

  assign o_clken = r_clken;

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Tone-sweep sequencer driving an NCO's phase increment and clock-enable.
// A config handshake loads start/step/tone count/dwell/divider/loop; the
// increment then steps through the tone list, holding each tone for a number
// of valid NCO output samples.
//   clk, reset_n      : system clock, async active-low reset
//   cfg_*             : config offer / accept and fields
//   abort             : synchronous stop request (ignored when idle)
//   nco_clken         : NCO clock-enable
//   nco_phi_inc       : NCO phase increment
//   nco_out_valid     : NCO output valid
//   tone_idx          : current tone index
//   busy/done/aborted : status; done and aborted are one-cycle pulses
//
// state | meaning
// IDLE  | waiting for config, cfg_ready high
// PRIME | NCO running, waiting for the first valid sample
// RUN   | counting valid samples per tone and stepping the increment
// DONE  | single-cycle end-of-sweep, done pulse
module nco_sweep_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int APR = DEF_APR,
  parameter int NW  = DEF_NW,
  parameter int DW  = DEF_DW,
  parameter int VW  = DEF_VW
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [APR-1:0] cfg_start,
  input  logic [APR-1:0] cfg_step,
  input  logic [NW-1:0]  cfg_ntones,
  input  logic [DW-1:0]  cfg_dwell,
  input  logic [VW-1:0]  cfg_div,
  input  logic           cfg_loop,
  input  logic           abort,
  output logic           nco_clken,
  output logic [APR-1:0] nco_phi_inc,
  input  logic           nco_out_valid,
  output logic [NW-1:0]  tone_idx,
  output logic           busy,
  output logic           done,
  output logic           aborted
);

  state_e         r_state;
  logic [APR-1:0] r_phi;
  logic [NW-1:0]  r_tone;
  logic           r_busy;
  logic           r_done;
  logic           r_aborted;
  logic [DW-1:0]  r_dwell_left;
  logic [DW-1:0]  r_dwell_m1;
  logic [NW-1:0]  r_last_idx;
  logic [APR-1:0] r_start;
  logic [APR-1:0] r_step;
  logic [VW-1:0]  r_div;
  logic           r_loop;

  logic           w_clken;
  logic           w_active;
  logic           w_abort;
  logic           w_sample;
  logic           w_tone_end;
  logic           w_last_tone;
  logic           w_to_done;
  logic           w_div_clr;
  logic           w_div_en;
  logic [DW-1:0]  w_dwell_m1_in;
  logic [NW-1:0]  w_last_idx_in;

  // Dwell is a down-counter of remaining samples; zero counts behave as 1.
  assign w_dwell_m1_in = DW'(nz_to_one(32'(cfg_dwell)) - 32'd1);
  assign w_last_idx_in = NW'(nz_to_one(32'(cfg_ntones)) - 32'd1);

  assign w_active    = (r_state == PRIME) || (r_state == RUN);
  assign w_abort     = abort && (r_state != IDLE);
  assign w_sample    = w_active && w_clken && nco_out_valid;
  assign w_tone_end  = w_sample && (r_dwell_left == '0);
  assign w_last_tone = (r_tone == r_last_idx);
  assign w_to_done   = w_tone_end && w_last_tone && !r_loop;

  // The divider looks one cycle ahead: it must know whether the next cycle
  // is still PRIME/RUN so its registered enable lines up with the state.
  assign w_div_clr = (r_state == IDLE) && cfg_valid;
  assign w_div_en  = w_active && !w_abort && !w_to_done;

  nco_clken_div #(
    .VW(VW)
  ) u_div (
    .clk    (clk),
    .reset_n(reset_n),
    .i_clr  (w_div_clr),
    .i_en   (w_div_en),
    .i_div  (r_div),
    .o_clken(w_clken)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_phi        <= '0;
      r_tone       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_dwell_left <= '0;
      r_dwell_m1   <= '0;
      r_last_idx   <= '0;
      r_start      <= '0;
      r_step       <= '0;
      r_div        <= '0;
      r_loop       <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
      if (w_abort) begin
        // Beats any tone advance or DONE entry in the same cycle.
        r_state      <= IDLE;
        r_aborted    <= 1'b1;
        r_busy       <= 1'b0;
        r_phi        <= '0;
        r_tone       <= '0;
        r_dwell_left <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (cfg_valid) begin
              r_start      <= cfg_start;
              r_step       <= cfg_step;
              r_div        <= cfg_div;
              r_loop       <= cfg_loop;
              r_last_idx   <= w_last_idx_in;
              r_dwell_m1   <= w_dwell_m1_in;
              r_dwell_left <= w_dwell_m1_in;
              r_phi        <= cfg_start;
              r_tone       <= '0;
              r_busy       <= 1'b1;
              r_state      <= PRIME;
            end
          end
          PRIME, RUN: begin
            if (w_tone_end) begin
              r_dwell_left <= r_dwell_m1;
              if (!w_last_tone) begin
                r_phi   <= r_phi + r_step;
                r_tone  <= r_tone + 1'b1;
                r_state <= RUN;
              end else if (r_loop) begin
                r_phi   <= r_start;
                r_tone  <= '0;
                r_state <= RUN;
              end else begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            end else if (w_sample) begin
              r_dwell_left <= r_dwell_left - 1'b1;
              r_state      <= RUN;
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign cfg_ready   = (r_state == IDLE);
  assign nco_clken   = w_clken;
  assign nco_phi_inc = r_phi;
  assign tone_idx    = r_tone;
  assign busy        = r_busy;
  assign done        = r_done;
  assign aborted     = r_aborted;

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
module tb_nco_sweep_ctrl;

  localparam int APR = 16;
  localparam int NW  = 12;
  localparam int DW  = 16;
  localparam int VW  = 8;

  logic           clk;
  logic           reset_n;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [APR-1:0] cfg_start;
  logic [APR-1:0] cfg_step;
  logic [NW-1:0]  cfg_ntones;
  logic [DW-1:0]  cfg_dwell;
  logic [VW-1:0]  cfg_div;
  logic           cfg_loop;
  logic           abort;
  logic           nco_clken;
  logic [APR-1:0] nco_phi_inc;
  logic           nco_out_valid;
  logic [NW-1:0]  tone_idx;
  logic           busy;
  logic           done;
  logic           aborted;

  int total = 0;
  int bad   = 0;

  nco_sweep_ctrl #(
    .APR(APR), .NW(NW), .DW(DW), .VW(VW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_start    (cfg_start),
    .cfg_step     (cfg_step),
    .cfg_ntones   (cfg_ntones),
    .cfg_dwell    (cfg_dwell),
    .cfg_div      (cfg_div),
    .cfg_loop     (cfg_loop),
    .abort        (abort),
    .nco_clken    (nco_clken),
    .nco_phi_inc  (nco_phi_inc),
    .nco_out_valid(nco_out_valid),
    .tone_idx     (tone_idx),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sweep described by cycles since start and samples
  // taken; tone and increment follow arithmetically from the sample count.
  int             m_act;   // 0 idle, 1 sweeping, 2 end-of-sweep cycle
  int             m_k;
  int             m_s;
  int             m_nt;
  int             m_dw;
  int             m_div;
  int             m_tone;
  int             m_tc;
  logic           m_loop;
  logic [APR-1:0] m_start;
  logic [APR-1:0] m_step;
  logic [APR-1:0] m_phi;
  logic           m_busy;
  logic           m_done;
  logic           m_abt;
  logic           m_clken;
  logic           m_smp;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_act = 0; m_k = 0; m_s = 0; m_nt = 1; m_dw = 1; m_div = 0; m_tone = 0;
      m_loop = 1'b0; m_start = '0; m_step = '0; m_phi = '0;
      m_busy = 1'b0; m_done = 1'b0; m_abt = 1'b0; m_clken = 1'b0;
    end else begin
      m_done = 1'b0;
      m_abt  = 1'b0;
      m_smp  = m_clken && nco_out_valid;
      if (m_act == 0) begin
        if (cfg_valid) begin
          m_start = cfg_start;
          m_step  = cfg_step;
          m_nt    = (cfg_ntones == '0) ? 1 : int'(cfg_ntones);
          m_dw    = (cfg_dwell == '0) ? 1 : int'(cfg_dwell);
          m_div   = int'(cfg_div);
          m_loop  = cfg_loop;
          m_act   = 1; m_k = 0; m_s = 0; m_tone = 0;
          m_phi   = cfg_start;
          m_busy  = 1'b1;
        end
      end else if (abort) begin
        m_act = 0; m_abt = 1'b1; m_busy = 1'b0; m_phi = '0; m_tone = 0;
      end else if (m_act == 2) begin
        m_act = 0; m_busy = 1'b0;
      end else begin
        m_k++;
        if (m_smp) begin
          m_s++;
          if (m_s % m_dw == 0) begin
            m_tc = m_s / m_dw;
            if (!m_loop && m_tc == m_nt) begin
              m_act  = 2;
              m_done = 1'b1;
            end else begin
              m_tone = m_tc % m_nt;
              m_phi  = APR'(32'(m_start) + 32'(m_step) * 32'(m_tone));
            end
          end
        end
      end
      m_clken = (m_act == 1) && (m_k % (m_div + 1) == 0);
    end
    #1;
    chk("m_clken",     32'(nco_clken),   32'(m_clken));
    chk("m_phi",       32'(nco_phi_inc), 32'(m_phi));
    chk("m_tone",      32'(tone_idx),    32'(m_tone));
    chk("m_busy",      32'(busy),        32'(m_busy));
    chk("m_done",      32'(done),        32'(m_done));
    chk("m_aborted",   32'(aborted),     32'(m_abt));
    chk("m_cfg_ready", 32'(cfg_ready),   32'(m_act == 0));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setcfg(input logic [APR-1:0] s, input logic [APR-1:0] st,
                        input int nt, input int dw, input int dv, input logic lp);
    cfg_start  = s;
    cfg_step   = st;
    cfg_ntones = NW'(nt);
    cfg_dwell  = DW'(dw);
    cfg_div    = VW'(dv);
    cfg_loop   = lp;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},   32'(cfg_ready),   32'd1);
    chk({tag, "_clken"},   32'(nco_clken),   32'd0);
    chk({tag, "_phi"},     32'(nco_phi_inc), 32'd0);
    chk({tag, "_tone"},    32'(tone_idx),    32'd0);
    chk({tag, "_busy"},    32'(busy),        32'd0);
    chk({tag, "_done"},    32'(done),        32'd0);
    chk({tag, "_aborted"}, 32'(aborted),     32'd0);
  endtask

  initial begin
    reset_n = 1'b0; cfg_valid = 1'b0; abort = 1'b0; nco_out_valid = 1'b0;
    setcfg('0, '0, 0, 0, 0, 1'b0);
    tick(2);
    chk_reset_vals("rst");
    reset_n = 1'b1;
    tick(1);

    // 3 tones x 4 samples, NCO valid after 9 clkens
    setcfg(16'h0100, 16'h0010, 3, 4, 0, 1'b0);
    cfg_valid = 1'b1;
    tick(1);                       // P0
    cfg_valid = 1'b0;
    chk("t1_p0_clken", 32'(nco_clken), 32'd1);
    chk("t1_p0_phi", 32'(nco_phi_inc), 32'h0100);
    tick(9);                       // P9
    nco_out_valid = 1'b1;
    tick(3);                       // P12
    chk("t1_p12_phi", 32'(nco_phi_inc), 32'h0100);
    tick(1);                       // P13
    chk("t1_p13_phi", 32'(nco_phi_inc), 32'h0110);
    chk("t1_p13_tone", 32'(tone_idx), 32'd1);
    tick(4);                       // P17
    chk("t1_p17_phi", 32'(nco_phi_inc), 32'h0120);
    tick(4);                       // P21
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_done_clken", 32'(nco_clken), 32'd0);
    tick(1);                       // P22
    chk("t1_idle_busy", 32'(busy), 32'd0);
    chk("t1_idle_ready", 32'(cfg_ready), 32'd1);
    chk("t1_idle_phi", 32'(nco_phi_inc), 32'h0120);

    // divider: clken every 4th cycle
    setcfg(16'h0200, 16'h0001, 2, 2, 3, 1'b0);
    cfg_valid = 1'b1;
    tick(1);                       // Q0
    cfg_valid = 1'b0;
    chk("t2_q0_clken", 32'(nco_clken), 32'd1);
    tick(1);
    chk("t2_q1_clken", 32'(nco_clken), 32'd0);
    tick(3);                       // Q4
    chk("t2_q4_clken", 32'(nco_clken), 32'd1);
    chk("t2_q4_phi", 32'(nco_phi_inc), 32'h0200);
    tick(1);                       // Q5
    chk("t2_q5_phi", 32'(nco_phi_inc), 32'h0201);
    tick(8);                       // Q13
    chk("t2_q13_done", 32'(done), 32'd1);
    tick(1);

    // looping sweep with increment wrap
    setcfg(16'hFFF8, 16'h0010, 2, 1, 0, 1'b1);
    cfg_valid = 1'b1;
    tick(1);                       // R0
    cfg_valid = 1'b0;
    tick(1);                       // R1
    chk("t3_wrap_phi", 32'(nco_phi_inc), 32'h0008);
    chk("t3_wrap_tone", 32'(tone_idx), 32'd1);
    tick(1);                       // R2
    chk("t3_reload_phi", 32'(nco_phi_inc), 32'hFFF8);
    chk("t3_reload_tone", 32'(tone_idx), 32'd0);
    chk("t3_reload_busy", 32'(busy), 32'd1);
    chk("t3_reload_clken", 32'(nco_clken), 32'd1);
    tick(3);                       // R5
    abort = 1'b1;
    tick(1);                       // R6
    abort = 1'b0;
    chk("t3_abort_pulse", 32'(aborted), 32'd1);
    chk("t3_abort_phi", 32'(nco_phi_inc), 32'd0);
    chk("t3_abort_clken", 32'(nco_clken), 32'd0);
    chk("t3_abort_ready", 32'(cfg_ready), 32'd1);
    tick(1);

    // zero counts behave as one tone of one sample
    nco_out_valid = 1'b0;
    setcfg(16'h0ABC, 16'h0001, 0, 0, 0, 1'b0);
    cfg_valid = 1'b1;
    tick(1);                       // S0
    cfg_valid = 1'b0;
    tick(2);                       // S2
    nco_out_valid = 1'b1;
    chk("t4_s2_done", 32'(done), 32'd0);
    tick(1);                       // S3
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_done_phi", 32'(nco_phi_inc), 32'h0ABC);
    tick(2);

    // abort on the final dwell sample
    setcfg(16'h1234, 16'h0001, 1, 2, 0, 1'b0);
    cfg_valid = 1'b1;
    tick(1);                       // T0
    cfg_valid = 1'b0;
    tick(1);                       // T1
    abort = 1'b1;
    tick(1);                       // T2
    abort = 1'b0;
    chk("t5_aborted", 32'(aborted), 32'd1);
    chk("t5_no_done", 32'(done), 32'd0);
    chk("t5_phi", 32'(nco_phi_inc), 32'd0);
    tick(1);
    chk("t5_no_late_done", 32'(done), 32'd0);

    // cfg_valid held through a sweep, with a valid gap
    setcfg(16'h0300, 16'h0100, 2, 2, 1, 1'b0);
    cfg_valid = 1'b1;
    tick(1);                       // U0
    setcfg(16'h0777, 16'h0000, 1, 5, 0, 1'b0);
    tick(2);                       // U2
    nco_out_valid = 1'b0;
    tick(1);                       // U3
    nco_out_valid = 1'b1;
    tick(1);                       // U4
    chk("t6_held_ready", 32'(cfg_ready), 32'd0);
    chk("t6_held_phi", 32'(nco_phi_inc), 32'h0300);
    tick(1);                       // U5
    chk("t6_u5_phi", 32'(nco_phi_inc), 32'h0400);
    tick(4);                       // U9
    chk("t6_done", 32'(done), 32'd1);
    tick(1);                       // U10
    chk("t6_idle_ready", 32'(cfg_ready), 32'd1);
    chk("t6_idle_phi", 32'(nco_phi_inc), 32'h0400);
    tick(1);                       // U11
    cfg_valid = 1'b0;
    chk("t6_reload_phi", 32'(nco_phi_inc), 32'h0777);
    chk("t6_reload_busy", 32'(busy), 32'd1);
    tick(1);                       // U12
    #1 reset_n = 1'b0;
    #1 chk_reset_vals("arst");
    tick(1);
    reset_n = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
